pwm_peripheral: RTL and testbench

Consumes the five configuration registers written over SPI and drives the 16 chip outputs. Each output is one of three things: forced low, statically high, or a shared 8-bit PWM waveform. A prescaler sets the PWM frequency. The duty cycle goes through a shadow register that updates only at period boundaries, so a duty change never glitches the waveform mid-period. The block sits directly downstream of the SPI register file in the top level.

---
 rtl/pwm_peripheral.sv | 71 +++++++
 tb/tb_pwm_peripheral.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel output driver with one shared 8-bit PWM waveform.
//   clk, rst_n            : clock, asynchronous active-low reset
//   en_reg_out_15_8/7_0   : per-channel output enable
//   en_reg_pwm_15_8/7_0   : per-channel PWM-mode select (static high when 0)
//   pwm_duty_cycle        : requested duty, loaded into the shadow at each wrap
//   out                   : registered channel outputs
//   period_strobe         : registered one-clk pulse on the first step of each period
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_strobe
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [7:0]       r_pwm_cnt;
  logic [7:0]       w_cnt_nxt;
  logic [7:0]       r_duty_sh;
  logic [7:0]       w_duty_nxt;
  logic             w_tick;
  logic             w_wrap;
  logic             w_pwm_raw;
  logic [15:0]      w_en_out;
  logic [15:0]      w_en_pwm;
  logic [15:0]      w_out_nxt;

  // Counter/shadow next state. The waveform is evaluated on the next-state
  // step and duty so that the registered out shows step 0 with the new duty
  // in the very clk that period_strobe is high.
  always_comb begin
    w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    w_tick     = (r_pre_cnt == PRE_MAX);
    w_wrap     = w_tick && (r_pwm_cnt == 8'hFF);
    w_pre_nxt  = w_tick ? '0 : r_pre_cnt + PRE_W'(1);
    w_cnt_nxt  = w_tick ? r_pwm_cnt + 8'd1 : r_pwm_cnt;
    w_duty_nxt = w_wrap ? pwm_duty_cycle : r_duty_sh;
    // Duty 255 is forced fully high rather than 255/256.
    w_pwm_raw  = (w_duty_nxt == 8'hFF) || (w_cnt_nxt < w_duty_nxt);
    w_out_nxt  = w_en_out & (~w_en_pwm | {16{w_pwm_raw}});
  end

  // Counters, duty shadow and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt     <= '0;
      r_pwm_cnt     <= 8'd0;
      r_duty_sh     <= 8'd0;
      out           <= 16'h0000;
      period_strobe <= 1'b0;
    end else begin
      r_pre_cnt     <= w_pre_nxt;
      r_pwm_cnt     <= w_cnt_nxt;
      r_duty_sh     <= w_duty_nxt;
      out           <= w_out_nxt;
      period_strobe <= w_wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench: two instances (PRESCALE=1 and PRESCALE=13) share the
// stimulus and are compared every clk against an arithmetic model that derives
// step, strobe and loaded duty from the number of clks since reset release.
module tb_pwm_peripheral;

  logic        clk;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out1, out13;
  logic        stb1, stb13;

  int n_vec;
  int n_err;
  int n_clk [2];
  logic [7:0] m_duty [2];
  int cyc;
  int last13;

  pwm_peripheral #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out1), .period_strobe(stb1)
  );

  pwm_peripheral #(.PRESCALE(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out13), .period_strobe(stb13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at clk %0d: got %h, want %h", tag, cyc, got, want);
    end
  endtask

  function automatic int presc(input int k);
    return (k == 0) ? 1 : 13;
  endfunction

  // Expected outputs after n clks since release with duty d currently loaded.
  function automatic logic [15:0] exp_out(input int p, input int n, input logic [7:0] d);
    int   stp;
    logic raw;
    logic [15:0] eo, ep;
    stp = (n / p) % 256;
    raw = (d == 8'd255) || (stp < int'(d));
    eo  = {eo_hi, eo_lo};
    ep  = {ep_hi, ep_lo};
    return eo & (~ep | {16{raw}});
  endfunction

  function automatic logic exp_stb(input int p, input int n);
    return (n > 0) && ((n % (256 * p)) == 0);
  endfunction

  // One clk: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      n_clk[k]++;
      if ((n_clk[k] % (256 * presc(k))) == 0) m_duty[k] = duty;
    end
    #1;
    chk("out_p1",  32'(out1),  32'(exp_out(1,  n_clk[0], m_duty[0])));
    chk("stb_p1",  32'(stb1),  32'(exp_stb(1,  n_clk[0])));
    chk("out_p13", 32'(out13), 32'(exp_out(13, n_clk[1], m_duty[1])));
    chk("stb_p13", 32'(stb13), 32'(exp_stb(13, n_clk[1])));
    if (stb13) begin
      if (last13 >= 0) chk("stb_interval_p13", 32'(cyc - last13), 32'd3328);
      last13 = cyc;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_p1",  32'(out1),  32'd0);
    chk("rst_async_stb_p1",  32'(stb1),  32'd0);
    chk("rst_async_out_p13", 32'(out13), 32'd0);
    chk("rst_async_stb_p13", 32'(stb13), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_out_p13", 32'(out13), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n_clk[k]  = 0;
      m_duty[k] = 8'd0;
    end
    last13 = -1;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cyc    = 0;
    last13 = -1;
    rst_n  = 1'b0;
    set_en(16'h0000, 16'h0000);
    duty   = 8'd0;
    for (int k = 0; k < 2; k++) begin
      n_clk[k]  = 0;
      m_duty[k] = 8'd0;
    end
    #1;
    chk("reset_out", 32'(out1), 32'd0);
    chk("reset_stb", 32'(stb13), 32'd0);
    #12;
    rst_n = 1'b1;

    // Duty 128, all channels PWM.
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'd128;
    run(1000);
    // Duty extremes.
    duty = 8'd0;
    run(800);
    duty = 8'd255;
    run(800);
    // Mixed modes, then drop channel 0.
    set_en(16'h00FF, 16'h000F);
    duty = 8'd64;
    run(600);
    set_en(16'h00FE, 16'h000F);
    run(300);
    // Mid-period duty change at step 100 of the PRESCALE=1 instance.
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'd32;
    run(300);
    while ((n_clk[0] % 256) != 100) step();
    duty = 8'd200;
    run(600);
    // Randomised enables and duty.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63, 0) == 0) set_en(16'($urandom), 16'($urandom));
      if ($urandom_range(199, 0) == 0) duty = 8'($urandom);
      step();
    end
    // Reset while outputs are high, then duty 10 on the default prescaler.
    set_en(16'hFFFF, 16'h0F0F);
    duty = 8'd255;
    run(20);
    do_reset();
    duty = 8'd10;
    run(7000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
